// File: rtl/rst_seq_pkg.sv
// Shared definitions for the staged reset sequencer.
//   state_t    : FSM encoding (HOLD=0, COUNT=1, DONE=2, SW_HOLD=3)
//   MAX_STAGES : upper limit on the number of staged reset outputs
package rst_seq_pkg;

    localparam int unsigned MAX_STAGES = 8;

    typedef enum logic [1:0] {
        ST_HOLD    = 2'd0,
        ST_COUNT   = 2'd1,
        ST_DONE    = 2'd2,
        ST_SW_HOLD = 2'd3
    } state_t;

endpackage : rst_seq_pkg

// File: rtl/rst_stage_timer.sv
// Inter-stage delay counter. Counts 0..STAGE_CYCLES-1 while enabled and
// flags the terminal count with a combinational one-cycle tick.
// Ports:
//   pclk    in  pixel clock
//   rst_n   in  async active-low reset
//   clear   in  synchronous clear to 0 (wins over enable)
//   enable  in  count enable
//   tick_c  out high while enabled at the terminal count (combinational)
module rst_stage_timer #(
    parameter int unsigned STAGE_CYCLES = 16
) (
    input  logic pclk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic tick_c
);

    localparam int unsigned CNT_W = (STAGE_CYCLES > 1) ? $clog2(STAGE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STAGE_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    assign tick_c = enable && (cnt == CNT_MAX);

    // Counter wraps to 0 on the tick so the next stage interval starts cleanly.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= tick_c ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule : rst_stage_timer

// File: rtl/reset_sequencer.sv
// Staged reset release: after rst_n rises, stage_rst bits are released one
// at a time, lowest index first, STAGE_CYCLES pclk cycles apart.
// Optional feature macro: RESET_SEQ_SOFT_RST_EN enables the sw_rst_req
// soft reset that re-runs the whole sequence.
// Ports:
//   pclk        in   pixel clock
//   rst_n       in   async active-low reset
//   sw_rst_req  in   soft reset request (level, pclk-synchronous)
//   stage_rst   out  active-high reset per domain, bit k = stage k (registered)
//   seq_done    out  high once every stage is released (registered)
module reset_sequencer
    import rst_seq_pkg::*;
#(
    parameter int unsigned NUM_STAGES   = 3,
    parameter int unsigned STAGE_CYCLES = 16
) (
    input  logic                  pclk,
    input  logic                  rst_n,
    input  logic                  sw_rst_req,
    output logic [NUM_STAGES-1:0] stage_rst,
    output logic                  seq_done
);

    localparam int unsigned IDX_W = $clog2(NUM_STAGES + 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_STAGES - 1);

    state_t                state, state_next;
    logic [IDX_W-1:0]      idx, idx_next;
    logic [NUM_STAGES-1:0] stage_rst_next;
    logic                  seq_done_next;
    logic                  timer_clr_c;
    logic                  timer_en_c;
    logic                  tick_c;

`ifndef RESET_SEQ_SOFT_RST_EN
    logic unused_sw_rst_req;
    assign unused_sw_rst_req = sw_rst_req;
`endif

    rst_stage_timer #(
        .STAGE_CYCLES (STAGE_CYCLES)
    ) u_timer (
        .pclk   (pclk),
        .rst_n  (rst_n),
        .clear  (timer_clr_c),
        .enable (timer_en_c),
        .tick_c (tick_c)
    );

    // State, stage index and output registers.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_HOLD;
            idx       <= '0;
            stage_rst <= '1;
            seq_done  <= 1'b0;
        end else begin
            state     <= state_next;
            idx       <= idx_next;
            stage_rst <= stage_rst_next;
            seq_done  <= seq_done_next;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_next     = state;
        idx_next       = idx;
        stage_rst_next = stage_rst;
        seq_done_next  = seq_done;
        timer_clr_c    = 1'b1;
        timer_en_c     = 1'b0;

        case (state)
            ST_HOLD: begin
                state_next = ST_COUNT;
            end
            ST_COUNT: begin
                timer_clr_c = 1'b0;
                timer_en_c  = 1'b1;
                if (tick_c) begin
                    for (int unsigned k = 0; k < NUM_STAGES; k++) begin
                        if (idx == IDX_W'(k)) begin
                            stage_rst_next[k] = 1'b0;
                        end
                    end
                    idx_next = idx + IDX_W'(1);
                    if (idx == IDX_LAST) begin
                        seq_done_next = 1'b1;
                        state_next    = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_next = ST_DONE;
            end
`ifdef RESET_SEQ_SOFT_RST_EN
            ST_SW_HOLD: begin
                if (!sw_rst_req) begin
                    state_next = ST_COUNT;
                end
            end
`endif
            default: begin
                state_next = ST_HOLD;
            end
        endcase

`ifdef RESET_SEQ_SOFT_RST_EN
        // Soft reset overrides any release happening on the same edge.
        if (sw_rst_req && ((state == ST_COUNT) || (state == ST_DONE))) begin
            state_next     = ST_SW_HOLD;
            idx_next       = '0;
            stage_rst_next = '1;
            seq_done_next  = 1'b0;
            timer_clr_c    = 1'b1;
            timer_en_c     = 1'b0;
        end
`endif
    end

endmodule : reset_sequencer
